// File: rtl/iob_cache_replace_arbiter.sv
// Purpose: round-robin share of one back-end line-refill port between two cache front-ends.
// Latency: grant/issue 1 cycle after a request is sampled in IDLE; read beats pass through combinationally.
// Backpressure: no new grant while the back-end reports busy; requester valids are ignored outside IDLE.
module iob_cache_replace_arbiter #(
   parameter int REPL_ADDR_W = 28,
   parameter int LINE2BE_W   = 2,
   parameter int BE_DATA_W   = 32
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   // requester 0
   input  logic                   r0_replace_valid_i,
   input  logic [REPL_ADDR_W-1:0] r0_replace_addr_i,
   output logic                   r0_replace_o,
   output logic                   r0_read_valid_o,
   output logic [LINE2BE_W-1:0]   r0_read_addr_o,
   output logic [BE_DATA_W-1:0]   r0_read_rdata_o,
   // requester 1
   input  logic                   r1_replace_valid_i,
   input  logic [REPL_ADDR_W-1:0] r1_replace_addr_i,
   output logic                   r1_replace_o,
   output logic                   r1_read_valid_o,
   output logic [LINE2BE_W-1:0]   r1_read_addr_o,
   output logic [BE_DATA_W-1:0]   r1_read_rdata_o,
   // back-end
   output logic                   be_replace_valid_o,
   output logic [REPL_ADDR_W-1:0] be_replace_addr_o,
   input  logic                   be_replace_i,
   input  logic                   be_read_valid_i,
   input  logic [LINE2BE_W-1:0]   be_read_addr_i,
   input  logic [BE_DATA_W-1:0]   be_read_rdata_i,
   // status
   output logic                   grant_o,
   output logic                   err_o
);

   // Beat counter is one bit wider than the line index so a long burst is
   // distinguishable from a complete one.
   localparam int CNT_W = LINE2BE_W + 1;
   localparam logic [CNT_W-1:0] LINE_BEATS = {1'b1, {LINE2BE_W{1'b0}}};
   localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_BUSY  = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic                   grant_q, grant_d;
   logic                   last_q, last_d;
   logic [REPL_ADDR_W-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]       beat_cnt_q, beat_cnt_d;
   logic                   err_q, err_d;

   // Decoded conditions shared by the next-state and datapath logic.
   logic req_any;
   logic arb_pick;
   logic arb_go;
   logic refill_done;
   logic in_refill;

   // Arbitration decision: tie goes to the requester that did not finish last.
   always_comb begin
      req_any     = r0_replace_valid_i | r1_replace_valid_i;
      arb_pick    = (r0_replace_valid_i & r1_replace_valid_i) ? ~last_q : r1_replace_valid_i;
      arb_go      = (state_q == ST_IDLE) & ~be_replace_i & req_any;
      refill_done = (state_q == ST_BUSY) & ~be_replace_i;
      in_refill   = (state_q != ST_IDLE);
   end

   // State register and datapath flops; reset aborts any refill in progress.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         grant_q    <= 1'b0;
         last_q     <= 1'b1;
         addr_q     <= '0;
         beat_cnt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         last_q     <= last_d;
         addr_q     <= addr_d;
         beat_cnt_q <= beat_cnt_d;
         err_q      <= err_d;
      end
   end

   // Next-state: IDLE -> ISSUE on grant, ISSUE -> BUSY on back-end ack, BUSY -> IDLE when it drops.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (arb_go) begin
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (be_replace_i) begin
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (!be_replace_i) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Datapath: latch owner and address on grant, count beats, flag protocol errors.
   always_comb begin
      grant_d    = grant_q;
      last_d     = last_q;
      addr_d     = addr_q;
      beat_cnt_d = beat_cnt_q;
      err_d      = err_q;

      if (arb_go) begin
         grant_d    = arb_pick;
         addr_d     = arb_pick ? r1_replace_addr_i : r0_replace_addr_i;
         beat_cnt_d = '0;
      end

      // Beats only count while a refill is owned; the counter sticks at all-ones.
      if (in_refill && be_read_valid_i && (beat_cnt_q != CNT_MAX)) begin
         beat_cnt_d = beat_cnt_q + 1'b1;
      end

      // A beat with no owner is dropped and flagged.
      if (!in_refill && be_read_valid_i) begin
         err_d = 1'b1;
      end

      if (refill_done) begin
         last_d = grant_q;
         if (beat_cnt_q != LINE_BEATS) begin
            err_d = 1'b1;
         end
      end
   end

   // Outputs: only the valids are steered to the owner; address and data fan out ungated.
   always_comb begin
      r0_replace_o       = in_refill & ~grant_q;
      r1_replace_o       = in_refill &  grant_q;
      r0_read_valid_o    = be_read_valid_i & in_refill & ~grant_q;
      r1_read_valid_o    = be_read_valid_i & in_refill &  grant_q;
      r0_read_addr_o     = be_read_addr_i;
      r1_read_addr_o     = be_read_addr_i;
      r0_read_rdata_o    = be_read_rdata_i;
      r1_read_rdata_o    = be_read_rdata_i;
      be_replace_valid_o = (state_q == ST_ISSUE);
      be_replace_addr_o  = addr_q;
      grant_o            = grant_q;
      err_o              = err_q;
   end

endmodule

// File: tb/tb_iob_cache_replace_arbiter.sv
// Bench for the two-port line-refill arbiter.
// Drives inputs and samples outputs on the falling clock edge.
// Reference model tracks pending requests, last owner and sticky error at transaction level.
module tb_iob_cache_replace_arbiter;

   localparam int AW    = 28;
   localparam int LW    = 2;
   localparam int DW    = 32;
   localparam int BEATS = 4;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          r0_replace_valid_i, r1_replace_valid_i;
   logic [AW-1:0] r0_replace_addr_i, r1_replace_addr_i;
   logic          r0_replace_o, r1_replace_o;
   logic          r0_read_valid_o, r1_read_valid_o;
   logic [LW-1:0] r0_read_addr_o, r1_read_addr_o;
   logic [DW-1:0] r0_read_rdata_o, r1_read_rdata_o;
   logic          be_replace_valid_o;
   logic [AW-1:0] be_replace_addr_o;
   logic          be_replace_i;
   logic          be_read_valid_i;
   logic [LW-1:0] be_read_addr_i;
   logic [DW-1:0] be_read_rdata_i;
   logic          grant_o;
   logic          err_o;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   logic m_last;
   logic m_err;

   always #5 clk_i = ~clk_i;

   iob_cache_replace_arbiter #(
      .REPL_ADDR_W(AW),
      .LINE2BE_W  (LW),
      .BE_DATA_W  (DW)
   ) dut (
      .clk_i              (clk_i),
      .rst_i              (rst_i),
      .r0_replace_valid_i (r0_replace_valid_i),
      .r0_replace_addr_i  (r0_replace_addr_i),
      .r0_replace_o       (r0_replace_o),
      .r0_read_valid_o    (r0_read_valid_o),
      .r0_read_addr_o     (r0_read_addr_o),
      .r0_read_rdata_o    (r0_read_rdata_o),
      .r1_replace_valid_i (r1_replace_valid_i),
      .r1_replace_addr_i  (r1_replace_addr_i),
      .r1_replace_o       (r1_replace_o),
      .r1_read_valid_o    (r1_read_valid_o),
      .r1_read_addr_o     (r1_read_addr_o),
      .r1_read_rdata_o    (r1_read_rdata_o),
      .be_replace_valid_o (be_replace_valid_o),
      .be_replace_addr_o  (be_replace_addr_o),
      .be_replace_i       (be_replace_i),
      .be_read_valid_i    (be_read_valid_i),
      .be_read_addr_i     (be_read_addr_i),
      .be_read_rdata_i    (be_read_rdata_i),
      .grant_o            (grant_o),
      .err_o              (err_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Round-robin rule: on a tie the requester that did not finish last wins.
   function automatic logic winner(input logic v0, input logic v1);
      if (v0 && v1) return ~m_last;
      return v1;
   endfunction

   task automatic all_outputs_zero(input string tag);
      chk({tag, "_r0_replace"}, r0_replace_o, 0);
      chk({tag, "_r1_replace"}, r1_replace_o, 0);
      chk({tag, "_r0_rvalid"}, r0_read_valid_o, 0);
      chk({tag, "_r1_rvalid"}, r1_read_valid_o, 0);
      chk({tag, "_be_valid"}, be_replace_valid_o, 0);
      chk({tag, "_be_addr"}, be_replace_addr_o, 0);
      chk({tag, "_grant"}, grant_o, 0);
      chk({tag, "_err"}, err_o, 0);
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      rst_i              = 1'b1;
      r0_replace_valid_i = 1'b0;
      r1_replace_valid_i = 1'b0;
      be_replace_i       = 1'b0;
      be_read_valid_i    = 1'b0;
      be_read_addr_i     = '0;
      be_read_rdata_i    = '0;
      @(negedge clk_i);
      all_outputs_zero("rst");
      rst_i  = 1'b0;
      m_last = 1'b1;
      m_err  = 1'b0;
   endtask

   // Serve one refill as the back-end. Must be called right after the request
   // is driven in IDLE (or right after the back-end stops being busy), so the
   // issue is expected exactly one cycle later.
   task automatic do_refill(input int nbeats, input logic owner, input logic [AW-1:0] exp_addr);
      int            waited;
      logic          seen;
      logic [LW-1:0] ba;
      logic [DW-1:0] d;
      seen   = 1'b0;
      waited = 0;
      while (!seen && waited < 20) begin
         @(negedge clk_i);
         waited++;
         seen = be_replace_valid_o;
      end
      chk("issue_seen", seen, 1);
      if (!seen) return;
      chk("issue_latency", waited, 1);
      chk("grant", grant_o, owner);
      chk("replace_own", owner ? r1_replace_o : r0_replace_o, 1);
      chk("replace_other", owner ? r0_replace_o : r1_replace_o, 0);
      chk("be_addr", be_replace_addr_o, exp_addr);
      chk("err_hold", err_o, m_err);
      if (owner) r1_replace_valid_i = 1'b0;
      else       r0_replace_valid_i = 1'b0;
      be_replace_i = 1'b1;
      @(negedge clk_i);
      chk("be_valid_drop", be_replace_valid_o, 0);
      for (int b = 0; b < nbeats; b++) begin
         if (b > 0) @(negedge clk_i);
         ba              = LW'(b);
         d               = $urandom;
         be_read_valid_i = 1'b1;
         be_read_addr_i  = ba;
         be_read_rdata_i = d;
         #1;
         chk("rvalid_own", owner ? r1_read_valid_o : r0_read_valid_o, 1);
         chk("rvalid_other", owner ? r0_read_valid_o : r1_read_valid_o, 0);
         chk("raddr", owner ? r1_read_addr_o : r0_read_addr_o, ba);
         chk("rdata", owner ? r1_read_rdata_o : r0_read_rdata_o, d);
      end
      @(negedge clk_i);
      be_read_valid_i = 1'b0;
      be_replace_i    = 1'b0;
      chk("replace_hold", owner ? r1_replace_o : r0_replace_o, 1);
      @(negedge clk_i);
      m_err  = m_err | (nbeats != BEATS);
      m_last = owner;
      chk("replace_fall_r0", r0_replace_o, 0);
      chk("replace_fall_r1", r1_replace_o, 0);
      chk("err_after", err_o, m_err);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic          o;
      logic [AW-1:0] a;
      rst_i              = 1'b1;
      r0_replace_valid_i = 1'b0;
      r1_replace_valid_i = 1'b0;
      r0_replace_addr_i  = '0;
      r1_replace_addr_i  = '0;
      be_replace_i       = 1'b0;
      be_read_valid_i    = 1'b0;
      be_read_addr_i     = '0;
      be_read_rdata_i    = '0;
      m_last             = 1'b1;
      m_err              = 1'b0;

      do_reset();

      // single refill for requester 0
      r0_replace_addr_i  = 28'h0000ABC;
      r0_replace_valid_i = 1'b1;
      do_refill(BEATS, 1'b0, 28'h0000ABC);

      // both valid from reset: strict alternation r0, r1, r0, r1
      do_reset();
      r0_replace_addr_i  = AW'($urandom);
      r1_replace_addr_i  = AW'($urandom);
      r0_replace_valid_i = 1'b1;
      r1_replace_valid_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         o = (i % 2 == 1);
         a = o ? r1_replace_addr_i : r0_replace_addr_i;
         do_refill(BEATS, o, a);
         if (i < 3) begin
            if (o) begin
               r1_replace_addr_i  = AW'($urandom);
               r1_replace_valid_i = 1'b1;
            end else begin
               r0_replace_addr_i  = AW'($urandom);
               r0_replace_valid_i = 1'b1;
            end
         end
      end
      r0_replace_valid_i = 1'b0;
      r1_replace_valid_i = 1'b0;

      // back-end busy in IDLE blocks the grant; lone r1 is granted back-to-back
      r1_replace_addr_i  = AW'($urandom);
      r1_replace_valid_i = 1'b1;
      be_replace_i       = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         chk("busy_no_grant", r1_replace_o, 0);
         chk("busy_no_issue", be_replace_valid_o, 0);
      end
      be_replace_i = 1'b0;
      do_refill(BEATS, 1'b1, r1_replace_addr_i);

      // short burst sets a sticky error that survives a later good refill
      r0_replace_addr_i  = AW'($urandom);
      r0_replace_valid_i = 1'b1;
      do_refill(3, 1'b0, r0_replace_addr_i);
      r1_replace_addr_i  = AW'($urandom);
      r1_replace_valid_i = 1'b1;
      do_refill(BEATS, 1'b1, r1_replace_addr_i);

      // long burst
      do_reset();
      r0_replace_addr_i  = AW'($urandom);
      r0_replace_valid_i = 1'b1;
      do_refill(5, 1'b0, r0_replace_addr_i);

      // reset in the middle of a refill, stray beat afterwards, then tie rule
      do_reset();
      r0_replace_addr_i  = AW'($urandom);
      r0_replace_valid_i = 1'b1;
      @(negedge clk_i);
      chk("mid_issue", r0_replace_o, 1);
      r0_replace_valid_i = 1'b0;
      be_replace_i       = 1'b1;
      for (int b = 0; b < 2; b++) begin
         @(negedge clk_i);
         be_read_valid_i = 1'b1;
         be_read_addr_i  = LW'(b);
         be_read_rdata_i = $urandom;
      end
      @(negedge clk_i);
      rst_i           = 1'b1;
      be_read_valid_i = 1'b0;
      be_replace_i    = 1'b0;
      be_read_addr_i  = '0;
      be_read_rdata_i = '0;
      @(negedge clk_i);
      all_outputs_zero("midrst");
      rst_i  = 1'b0;
      m_last = 1'b1;
      m_err  = 1'b0;
      be_read_valid_i = 1'b1;
      be_read_rdata_i = $urandom;
      #1;
      chk("stray_r0_rvalid", r0_read_valid_o, 0);
      chk("stray_r1_rvalid", r1_read_valid_o, 0);
      @(negedge clk_i);
      be_read_valid_i = 1'b0;
      chk("stray_err", err_o, 1);
      m_err = 1'b1;
      r0_replace_addr_i  = AW'($urandom);
      r1_replace_addr_i  = AW'($urandom);
      r0_replace_valid_i = 1'b1;
      r1_replace_valid_i = 1'b1;
      do_refill(BEATS, 1'b0, r0_replace_addr_i);
      r1_replace_valid_i = 1'b0;
      @(negedge clk_i);

      // randomized request patterns against the round-robin model
      do_reset();
      for (int i = 0; i < 40; i++) begin
         if (!r0_replace_valid_i && $urandom_range(0, 1) == 1) begin
            r0_replace_addr_i  = AW'($urandom);
            r0_replace_valid_i = 1'b1;
         end
         if (!r1_replace_valid_i && $urandom_range(0, 1) == 1) begin
            r1_replace_addr_i  = AW'($urandom);
            r1_replace_valid_i = 1'b1;
         end
         if (!r0_replace_valid_i && !r1_replace_valid_i) begin
            if ($urandom_range(0, 1) == 1) begin
               r1_replace_addr_i  = AW'($urandom);
               r1_replace_valid_i = 1'b1;
            end else begin
               r0_replace_addr_i  = AW'($urandom);
               r0_replace_valid_i = 1'b1;
            end
         end
         o = winner(r0_replace_valid_i, r1_replace_valid_i);
         a = o ? r1_replace_addr_i : r0_replace_addr_i;
         do_refill(BEATS, o, a);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
